// File: rtl/arith_pkg.sv
// Shared constants, state enum and decode bundle for the arithmetic sequencer.
package arith_pkg;

  // ALU operation codes
  localparam logic [2:0] ALU_ADDU = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  // Second ALU operand select
  localparam logic [1:0] ALU_SRC2_RT   = 2'd0;
  localparam logic [1:0] ALU_SRC2_SEXT = 2'd1;
  localparam logic [1:0] ALU_SRC2_ZEXT = 2'd2;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Decoded control bundle; all-zero means illegal with ADDU/rd/rtData selects
  typedef struct packed {
    logic       legal;
    logic       rd_src;
    logic [1:0] alu_src2;
    logic [2:0] alu_op;
  } dec_t;

endpackage

// File: rtl/arith_seq_decode.sv
// Combinational opcode/funct decoder for the arithmetic sequencer.
module arith_seq_decode
  import arith_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // Map instruction fields to {legal, rd_src, alu_src2, alu_op}
  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.legal    = 1'b1;
        dec.rd_src   = 1'b0;
        dec.alu_src2 = ALU_SRC2_RT;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_XOR:  dec.alu_op = ALU_XOR;
          FN_NOR:  dec.alu_op = ALU_NOR;
          default: dec = '0;
        endcase
      end
      OP_ADDI: dec = '{legal: 1'b1, rd_src: 1'b1, alu_src2: ALU_SRC2_SEXT, alu_op: ALU_ADD};
      OP_ANDI: dec = '{legal: 1'b1, rd_src: 1'b1, alu_src2: ALU_SRC2_ZEXT, alu_op: ALU_AND};
      OP_ORI:  dec = '{legal: 1'b1, rd_src: 1'b1, alu_src2: ALU_SRC2_ZEXT, alu_op: ALU_OR};
      OP_XORI: dec = '{legal: 1'b1, rd_src: 1'b1, alu_src2: ALU_SRC2_ZEXT, alu_op: ALU_XOR};
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/arith_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the arithmetic datapath.
// Optional build macro ARITH_SEQ_OVF_TRAP_EN: signed-add overflow in EXEC halts
// the machine instead of writing back.
module arith_sequencer
  import arith_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             imem_ready,
  input  logic             alu_overflow,
  output logic             imem_req,
  output logic             ir_en,
  output logic             alu_en,
  output logic             rf_we,
  output logic             pc_en,
  output logic             rd_src,
  output logic [1:0]       alu_src2,
  output logic [2:0]       alu_op,
  output logic             except,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  state_t             state, state_nxt;
  dec_t               dec;
  dec_t               dec_q;
  logic               except_q;
  logic [CNT_W-1:0]   retired_q;
  logic               ovf_trap;

  arith_seq_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

`ifdef ARITH_SEQ_OVF_TRAP_EN
  // Only the signed adds (add, addi) trap; the latched op identifies them
  assign ovf_trap = alu_overflow && (dec_q.alu_op == ALU_ADD);
`else
  logic unused_ovf;
  assign unused_ovf = alu_overflow;
  assign ovf_trap   = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = dec.legal ? S_EXEC : S_HALT;
      S_EXEC:   state_nxt = ovf_trap ? S_HALT : S_WB;
      S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore enables from state; ir_en additionally qualified by imem_ready
  always_comb begin
    imem_req = (state == S_FETCH);
    ir_en    = (state == S_FETCH) && imem_ready;
    alu_en   = (state == S_EXEC);
    rf_we    = (state == S_WB);
    pc_en    = (state == S_WB);
    busy     = (state != S_IDLE) && (state != S_HALT);
  end

  // Latch decoded selects in DECODE so they hold steady through EXEC and WB
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 dec_q <= '0;
    else if (state == S_DECODE) dec_q <= dec;
  end

  // Sticky exception flag, set on the transition into HALT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                    except_q <= 1'b0;
    else if ((state == S_DECODE) && !dec.legal)    except_q <= 1'b1;
    else if ((state == S_EXEC) && ovf_trap)        except_q <= 1'b1;
  end

  // Retired counter advances on the edge leaving WB, wrapping naturally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)             retired_q <= '0;
    else if (state == S_WB) retired_q <= retired_q + CNT_W'(1);
  end

  assign rd_src   = dec_q.rd_src;
  assign alu_src2 = dec_q.alu_src2;
  assign alu_op   = dec_q.alu_op;
  assign except   = except_q;
  assign retired  = retired_q;

endmodule

// File: doc/arith_sequencer.md
# arith_sequencer

Multi-cycle control sequencer for the arithmetic machine datapath (PC register, instruction memory, regfile, ALU, operand/destination muxes). Each instruction is stepped through fetch, decode, execute and writeback. The block drives every datapath enable and select. Datapath state changes only in the correct cycle, and execution halts cleanly on an unrecognised instruction. A retired-instruction counter is included for bring-up and measurement.

## Interface
- CNT_W, 16, width of the retired-instruction counter.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- run  in  1  1 = keep issuing instructions; 0 = stop at the next instruction boundary.
- opcode  in  6  inst[31:26] from the instruction register.
- funct  in  6  inst[5:0] from the instruction register.
- imem_ready  in  1  instruction memory data valid this cycle.
- alu_overflow  in  1  overflow flag from the execute ALU.
- imem_req  out  1  fetch request to instruction memory.
- ir_en  out  1  load the instruction register.
- alu_en  out  1  load the ALU result register.
- rf_we  out  1  regfile write enable.
- pc_en  out  1  PC register enable (PC <= PC + 4).
- rd_src  out  1  0 = rd (inst[15:11]), 1 = rt (inst[20:16]).
- alu_src2  out  2  0 = rtData, 1 = sign-extended imm16, 2 = zero-extended imm16.
- alu_op  out  3  ALU operation code (ADDU 0, ADD 2, SUB 3, AND 4, OR 5, NOR 6, XOR 7).
- except  out  1  sticky; 1 = halted on an illegal instruction or trap.
- busy  out  1  1 in every state except IDLE and HALT.
- retired  out  CNT_W  count of completed writebacks.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: all enables 0. Goes to FETCH when run=1.
- FETCH: imem_req=1.
  - imem_ready=1: ir_en=1 for that cycle, then DECODE.
  - Otherwise: stay in FETCH. There is no timeout.
- DECODE: decode opcode/funct and latch rd_src, alu_src2 and alu_op into registers. These hold stable through EXEC and WB.
  - R-type (opcode 0x00): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR. rd_src=0, alu_src2=0.
  - Immediate forms: rd_src=1.
    - 0x08 addi: ADD, alu_src2=1.
    - 0x0C andi: AND, alu_src2=2.
    - 0x0D ori: OR, alu_src2=2.
    - 0x0E xori: XOR, alu_src2=2.
  - Any other opcode/funct: illegal. Go to HALT and set except=1. rf_we, pc_en and retired are untouched.
  - Legal instruction: go to EXEC.
- EXEC: alu_en=1, then WB.
- WB: rf_we=1, pc_en=1, retired += 1. retired wraps from 2^CNT_W-1 to 0.
  - Next state is FETCH if run=1, otherwise IDLE.
- HALT: every enable is 0, except=1, busy=0. Only reset exits HALT.
- run=0 mid-instruction does not abort. The current instruction completes through WB, then the block goes to IDLE.
- imem_ready is ignored outside FETCH. alu_overflow is ignored outside EXEC.

## Timing
- Reset (reset=0): state goes to IDLE immediately.
  - All outputs 0, including except, busy and retired.
  - Latched decode fields cleared to 0 (alu_op=ADDU).
- All enables are Moore outputs of the state register, plus the imem_ready qualifier on ir_en. Select outputs come from the latched registers. No combinational path from opcode/funct to any output.
- Minimum 4 cycles per instruction (FETCH with imem_ready=1, DECODE, EXEC, WB). Each cycle imem_ready stays low adds 1 cycle.
- rf_we and pc_en are asserted in the same single cycle. The regfile and PC update at the rising edge that leaves WB.
- An illegal instruction is detected in DECODE. except rises at the edge that leaves DECODE.
- Reset asserted in any state: that cycle produces no rf_we and no pc_en.

## Configuration
- ARITH_SEQ_OVF_TRAP_EN defined: for ADD and addi only, alu_overflow=1 in EXEC sends the FSM to HALT with except=1. WB is skipped, so there is no regfile write, no PC update and no retire.
- Not defined: alu_overflow is unused and overflow results are written back normally.

## Structure
- Shared package arith_pkg holds:
  - ALU_* opcode constants.
  - The state enum.
  - ALU_SRC2_RT / ALU_SRC2_SEXT / ALU_SRC2_ZEXT constants.
  - Opcode and funct constants.
- One sub-module, arith_seq_decode: purely combinational, maps opcode/funct to {legal, rd_src, alu_src2, alu_op}.
- The top level holds the FSM, the latched decode registers and the retired counter.

## Test plan
- Reset, run=1, imem_ready=1, instruction add (op 0x00, funct 0x20):
  - DECODE→EXEC→WB on consecutive cycles. In WB, rf_we=pc_en=1, rd_src=0, alu_op=2, alu_src2=0. retired=1.
- ori (op 0x0D) with imem_ready low for 3 cycles in FETCH: ir_en pulses on the fourth FETCH cycle, rd_src=1, alu_src2=2, alu_op=5, WB 7 cycles after FETCH entry.
- Illegal op 0x3F after two legal instructions: except=1 and busy=0 from the cycle after DECODE, retired stays 2. Stays halted with run=1 until reset goes 0.
- run dropped during EXEC of andi: WB still completes (retired increments), then IDLE with imem_req=0.
- reset pulsed low during WB: rf_we and pc_en drop immediately, all outputs 0, state IDLE.
- With ARITH_SEQ_OVF_TRAP_EN, addi with alu_overflow=1 in EXEC: HALT, except=1, no rf_we, retired unchanged. Without the macro, the same stimulus gives a normal WB.
